// File: rtl/wdt_kick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wdt_kick_ctrl
//  Purpose  : APB master that brings up the secure watchdog (TORR, then CR)
//             and then services it autonomously. It kicks the watchdog once
//             per period, but only if the CPU supplied a heartbeat since the
//             last kick. On a watchdog interrupt it either clears it (EOI
//             read followed by a kick) or abandons the watchdog so that the
//             watchdog's system reset fires.
//  Ports    : pclk / prst_b           - clock, async active-low reset
//             start                   - launches init (sampled in IDLE only)
//             cfg_top / cfg_rmod      - TORR timeout / CR response mode
//             cfg_period              - pclk cycles per kick opportunity
//             heartbeat               - CPU health pulse
//             wdt_intr                - watchdog interrupt level
//             m_psel .. m_prdata      - APB master port (no pready)
//             busy / locked / miss_cnt- status
//  Revision : 1.0 - initial release
// ============================================================================
module wdt_kick_ctrl #(
    parameter int CNT_W  = 24,
    parameter int MISS_W = 4
) (
    input  logic              pclk,
    input  logic              prst_b,
    input  logic              start,
    input  logic [3:0]        cfg_top,
    input  logic              cfg_rmod,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              heartbeat,
    input  logic              wdt_intr,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [7:0]        m_paddr,
    output logic [31:0]       m_pwdata,
    input  logic [31:0]       m_prdata,
    output logic              busy,
    output logic              locked,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam logic [7:0]  C_ADDR_CR   = 8'h00;
    localparam logic [7:0]  C_ADDR_TORR = 8'h04;
    localparam logic [7:0]  C_ADDR_CRR  = 8'h0C;
    localparam logic [7:0]  C_ADDR_EOI  = 8'h14;
    localparam logic [31:0] C_KICK_VAL  = 32'h0000_0076;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT_TORR = 3'd1,
        S_INIT_CR   = 3'd2,
        S_RUN       = 3'd3,
        S_KICK      = 3'd4,
        S_CLR_EOI   = 3'd5,
        S_LOCKED    = 3'd6
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_period_m1;
    logic               r_hb_seen;

    logic               w_tick;
    logic               w_miss_sat;
    logic               w_hb_live;
    logic               w_unused_prdata;

    // The EOI read only clears the interrupt as a side effect; its data is
    // of no interest to this controller.
    assign w_unused_prdata = ^m_prdata;

    assign w_tick     = (r_cnt == r_period_m1);
    assign w_miss_sat = &miss_cnt;
    assign w_hb_live  = (r_state != S_IDLE) && (r_state != S_LOCKED);

    always_ff @(posedge pclk or negedge prst_b) begin
        if (!prst_b) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_period_m1 <= '0;
            r_hb_seen   <= 1'b0;
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            m_pwrite    <= 1'b0;
            m_paddr     <= 8'h00;
            m_pwdata    <= 32'h0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            miss_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_INIT_TORR;
                        m_psel      <= 1'b1;
                        m_penable   <= 1'b0;
                        m_pwrite    <= 1'b1;
                        m_paddr     <= C_ADDR_TORR;
                        m_pwdata    <= {24'h0, cfg_top, cfg_top};
                        busy        <= 1'b1;
                        // A zero period is folded to one cycle per tick.
                        r_period_m1 <= (cfg_period == '0) ? '0
                                                          : cfg_period - CNT_W'(1);
                    end
                end

                S_INIT_TORR: begin
                    if (!m_penable) begin
                        m_penable <= 1'b1;
                    end else begin
                        // Chain straight into the CR setup cycle.
                        r_state   <= S_INIT_CR;
                        m_penable <= 1'b0;
                        m_paddr   <= C_ADDR_CR;
                        m_pwdata  <= {30'h0, cfg_rmod, 1'b1};
                    end
                end

                S_INIT_CR: begin
                    if (!m_penable) begin
                        m_penable <= 1'b1;
                    end else begin
                        r_state   <= S_RUN;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        m_pwrite  <= 1'b0;
                        r_cnt     <= '0;
                        r_hb_seen <= 1'b0;
                    end
                end

                S_RUN: begin
                    // The interrupt outranks a coincident period tick.
                    if (wdt_intr) begin
                        if (r_hb_seen) begin
                            r_state   <= S_CLR_EOI;
                            m_psel    <= 1'b1;
                            m_penable <= 1'b0;
                            m_pwrite  <= 1'b0;
                            m_paddr   <= C_ADDR_EOI;
                        end else begin
                            r_state <= S_LOCKED;
                            busy    <= 1'b0;
                            locked  <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_cnt <= '0;
                        if (r_hb_seen) begin
                            r_state   <= S_KICK;
                            m_psel    <= 1'b1;
                            m_penable <= 1'b0;
                            m_pwrite  <= 1'b1;
                            m_paddr   <= C_ADDR_CRR;
                            m_pwdata  <= C_KICK_VAL;
                        end else if (!w_miss_sat) begin
                            miss_cnt <= miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_KICK: begin
                    if (!m_penable) begin
                        m_penable <= 1'b1;
                    end else begin
                        // Counter restarts here; after a plain tick it is
                        // already zero, after an EOI it may not be.
                        r_state   <= S_RUN;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        m_pwrite  <= 1'b0;
                        r_cnt     <= '0;
                        r_hb_seen <= 1'b0;
                    end
                end

                S_CLR_EOI: begin
                    if (!m_penable) begin
                        m_penable <= 1'b1;
                    end else begin
                        r_state   <= S_KICK;
                        m_penable <= 1'b0;
                        m_pwrite  <= 1'b1;
                        m_paddr   <= C_ADDR_CRR;
                        m_pwdata  <= C_KICK_VAL;
                    end
                end

                S_LOCKED: begin
                    // Terminal until reset.
                end

                default: begin
                    r_state   <= S_IDLE;
                    m_psel    <= 1'b0;
                    m_penable <= 1'b0;
                    m_pwrite  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase

            // Placed last so a heartbeat wins over any clear in the same cycle.
            if (heartbeat && w_hb_live) begin
                r_hb_seen <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wdt_kick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wdt_kick_ctrl
//  Purpose  : Self-checking bench for wdt_kick_ctrl. A transaction-queue
//             reference model predicts the APB bus and status every cycle;
//             directed checks cover the bring-up sequence, missed kicks,
//             interrupt clearing, lock-out and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wdt_kick_ctrl;

    localparam int CNT_W  = 24;
    localparam int MISS_W = 4;

    localparam int K_TORR = 0;
    localparam int K_CR   = 1;
    localparam int K_EOI  = 2;
    localparam int K_KICK = 3;

    logic              pclk;
    logic              prst_b;
    logic              start;
    logic [3:0]        cfg_top;
    logic              cfg_rmod;
    logic [CNT_W-1:0]  cfg_period;
    logic              heartbeat;
    logic              wdt_intr;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [7:0]        m_paddr;
    logic [31:0]       m_pwdata;
    logic [31:0]       m_prdata;
    logic              busy;
    logic              locked;
    logic [MISS_W-1:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    wdt_kick_ctrl #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
        .pclk       (pclk),
        .prst_b     (prst_b),
        .start      (start),
        .cfg_top    (cfg_top),
        .cfg_rmod   (cfg_rmod),
        .cfg_period (cfg_period),
        .heartbeat  (heartbeat),
        .wdt_intr   (wdt_intr),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_prdata   (m_prdata),
        .busy       (busy),
        .locked     (locked),
        .miss_cnt   (miss_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- reference model: queue of pending APB transfers -------
    bit          m_active;
    bit          m_locked;
    int          q[$];
    bit          m_ph;       // 0 = setup cycle, 1 = access cycle of q[0]
    int          m_cnt;
    int          m_period;
    bit          m_hb;
    int          m_miss;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_top;

    function automatic void model_reset();
        m_active = 0; m_locked = 0; q = {}; m_ph = 0;
        m_cnt = 0; m_period = 1; m_hb = 0; m_miss = 0;
        m_addr = 8'h00; m_data = 32'h0; m_top = 4'h0;
    endfunction

    function automatic void activate_head();
        case (q[0])
            K_TORR: begin m_addr = 8'h04; m_data = {24'h0, m_top, m_top}; end
            K_CR:   begin m_addr = 8'h00; m_data = {30'h0, cfg_rmod, 1'b1}; end
            K_EOI:  begin m_addr = 8'h14; end
            default: begin m_addr = 8'h0C; m_data = 32'h76; end
        endcase
    endfunction

    function automatic void model_step();
        bit hb_in;
        hb_in = heartbeat;
        if (!prst_b) begin model_reset(); return; end
        if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_top    = cfg_top;
                m_period = (cfg_period == 0) ? 1 : int'(cfg_period);
                q = {K_TORR, K_CR};
                m_ph = 0;
                activate_head();
            end
            return;
        end
        if (m_locked) return;
        if (q.size() != 0) begin
            if (!m_ph) m_ph = 1;
            else begin
                void'(q.pop_front());
                m_ph = 0;
                if (q.size() == 0) begin m_cnt = 0; m_hb = 0; end
                else activate_head();
            end
        end else if (wdt_intr) begin
            if (m_hb) begin q = {K_EOI, K_KICK}; m_ph = 0; activate_head(); end
            else m_locked = 1;
        end else if (m_cnt == m_period - 1) begin
            m_cnt = 0;
            if (m_hb) begin q = {K_KICK}; m_ph = 0; activate_head(); end
            else if (m_miss < 15) m_miss++;
        end else begin
            m_cnt++;
        end
        if (hb_in) m_hb = 1;
    endfunction

    // ---------------- checking ----------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [48:0] obs;
        logic [48:0] exp;
        bit          xfer;
        xfer = (q.size() != 0);
        obs = {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, busy, locked, miss_cnt};
        exp = {xfer, xfer && m_ph, xfer && (q[0] != K_EOI), m_addr, m_data,
               m_active && !m_locked, m_locked, 4'(m_miss)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        model_step();
        #1;
        check_outputs("cycle");
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        bit any_psel;
        bit saw_kick;
        bit found;

        prst_b = 1'b0; start = 1'b0; cfg_top = 4'h0; cfg_rmod = 1'b0;
        cfg_period = '0; heartbeat = 1'b0; wdt_intr = 1'b0;
        m_prdata = $urandom;
        model_reset();
        repeat (2) step();
        prst_b = 1'b1;
        repeat (2) step();
        chk("reset_psel", {31'h0, m_psel}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_paddr", {24'h0, m_paddr}, 32'h0);

        // Bring-up: TORR then CR, two cycles each; start held longer.
        cfg_top = 4'h5; cfg_rmod = 1'b1; cfg_period = 24'd10; start = 1'b1;
        step();
        chk("torr_setup", {m_psel, m_penable, m_pwrite, busy, 20'h0, m_paddr}, {4'b1011, 20'h0, 8'h04});
        chk("torr_data", m_pwdata, 32'h55);
        step();
        chk("torr_access", {m_psel, m_penable, 22'h0, m_paddr}, {2'b11, 22'h0, 8'h04});
        step();
        start = 1'b0;
        chk("cr_setup", {m_psel, m_penable, 22'h0, m_paddr}, {2'b10, 22'h0, 8'h00});
        chk("cr_data", m_pwdata, 32'h3);
        step();
        chk("cr_access", {30'h0, m_psel, m_penable}, 32'h3);
        step();
        chk("run_idle_bus", {30'h0, m_psel, busy}, 32'h1);

        // Heartbeat every 8 cycles: every tick kicks.
        for (int i = 0; i < 64; i++) begin
            heartbeat = (i % 8 == 0);
            step();
        end
        heartbeat = 1'b0;
        chk("miss_with_hb", {28'h0, miss_cnt}, 32'h0);

        // Drain any pending heartbeat, then 40 quiet cycles.
        for (int i = 0; i < 40; i++) begin
            if (!m_hb && q.size() == 0) break;
            step();
        end
        any_psel = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_psel) any_psel = 1;
        end
        chk("no_kick_quiet", {31'h0, any_psel}, 32'h0);
        chk("miss_quiet", {28'h0, miss_cnt}, 32'h4);

        heartbeat = 1'b1;
        step();
        heartbeat = 1'b0;
        saw_kick = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m_psel && m_pwrite && m_paddr == 8'h0C && m_pwdata == 32'h76) saw_kick = 1;
        end
        chk("kick_after_hb", {31'h0, saw_kick}, 32'h1);

        // Interrupt with a heartbeat pending: EOI read, then kick.
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0 && m_hb) break;
            heartbeat = 1'b1;
            step();
        end
        heartbeat = 1'b0;
        wdt_intr = 1'b1;
        step();
        wdt_intr = 1'b0;
        chk("eoi_setup", {m_psel, m_penable, m_pwrite, 21'h0, m_paddr}, {3'b100, 21'h0, 8'h14});
        step();
        chk("eoi_access", {m_psel, m_penable, m_pwrite, 21'h0, m_paddr}, {3'b110, 21'h0, 8'h14});
        step();
        chk("eoi_kick", {m_psel, m_penable, m_pwrite, 21'h0, m_paddr}, {3'b101, 21'h0, 8'h0C});
        chk("eoi_kick_data", m_pwdata, 32'h76);
        repeat (14) step();

        // Randomised heartbeats with occasional clearable interrupts.
        for (int i = 0; i < 200; i++) begin
            heartbeat = ($urandom_range(0, 9) == 0);
            wdt_intr  = ($urandom_range(0, 29) == 0) && m_hb;
            m_prdata  = $urandom;
            step();
        end
        heartbeat = 1'b0; wdt_intr = 1'b0;

        // Interrupt with no heartbeat: abandon the watchdog.
        repeat (30) step();
        wdt_intr = 1'b1;
        repeat (6) step();
        wdt_intr = 1'b0;
        any_psel = 0;
        for (int i = 0; i < 20; i++) begin
            heartbeat = $urandom_range(0, 1);
            start     = $urandom_range(0, 1);
            step();
            if (m_psel) any_psel = 1;
        end
        heartbeat = 1'b0; start = 1'b0;
        chk("locked_flag", {30'h0, locked, busy}, 32'h2);
        chk("locked_no_psel", {31'h0, any_psel}, 32'h0);

        // Reset, re-init with random config, async reset during a kick access.
        prst_b = 1'b0;
        step();
        prst_b = 1'b1;
        step();
        cfg_top = 4'($urandom); cfg_rmod = 1'($urandom); cfg_period = 24'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        heartbeat = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (q.size() != 0 && q[0] == K_KICK && m_ph) begin found = 1; break; end
        end
        chk("kick_access_found", {31'h0, found}, 32'h1);
        #2;
        prst_b = 1'b0;
        #1;
        chk("async_rst_bus", {29'h0, m_psel, m_penable, m_pwrite}, 32'h0);
        chk("async_rst_stat", {26'h0, busy, locked, miss_cnt}, 32'h0);
        chk("async_rst_addr", {24'h0, m_paddr}, 32'h0);
        model_reset();
        heartbeat = 1'b0;
        step();
        prst_b = 1'b1;
        step();
        chk("idle_after_rst", {30'h0, busy, m_psel}, 32'h0);

        // Period 0 behaves as period 1.
        cfg_period = '0; cfg_top = 4'hA; cfg_rmod = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        repeat (3) step();
        chk("period0_miss", {28'h0, miss_cnt}, 32'h3);
        for (int i = 0; i < 60; i++) begin
            heartbeat = ($urandom_range(0, 3) == 0);
            step();
        end
        heartbeat = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
